mem_access_unit: RTL
====================

# mem_access_unit

Data-memory access stage of the MIPS pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register. It handles loads and stores on a word-wide ready/ack memory bus with variable latency. It performs little-endian byte-lane steering, load sign- or zero-extension and misalignment detection, and stalls the pipeline until each access completes. Its outputs feed the MEM/WB register's rData/Result/wAddr inputs, and its stall output gates that register's enable.

## Interface
- TIMEOUT, 255: maximum number of BUSY cycles without mem_ack before the access is aborted; 8-bit counter.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- MemRead  in  1  current instruction is a load.
- MemWrite  in  1  current instruction is a store (MemRead and MemWrite both 1 is treated as a load).
- Size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- Unsigned  in  1  load zero-extends (1) or sign-extends (0).
- Addr  in  32  effective address (ALU result).
- wData_i  in  32  store data (rt value).
- wAddr_i  in  5  destination register number.
- rData  out  32  formatted load data.
- Result  out  32  equals Addr (combinational pass-through).
- wAddr  out  5  equals wAddr_i (combinational pass-through).
- stall  out  1  hold upstream stages and MEM/WB enable.
- misalign  out  1  misaligned access detected this cycle.
- bus_err  out  1  one-cycle pulse when an access times out.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  write strobe, registered.
- mem_addr  out  32  word address {Addr[31:2],2'b00}, registered.
- mem_be  out  4  byte enables, registered.
- mem_wdata  out  32  replicated store data, registered.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  access complete.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE, no memory operation: stall=0, rData=0, no transaction.
- IDLE, misaligned access:
  - Misaligned means halfword with Addr[0]=1, or word with Addr[1:0]≠0.
  - misalign=1 (combinational), stall=0, rData=0, no bus request, state stays IDLE.
- IDLE, aligned access:
  - stall=1.
  - Latch mem_addr, mem_we (=MemWrite & ~MemRead), mem_be, mem_wdata, Size, Unsigned and Addr[1:0].
  - Set mem_req=1 and go to BUSY.
- Byte enables:
  - byte: 4'b0001<<Addr[1:0].
  - halfword: 4'b0011<<Addr[1:0].
  - word: 4'b1111.
- Store data:
  - byte: {4{wData_i[7:0]}}.
  - halfword: {2{wData_i[15:0]}}.
  - word: wData_i.
- BUSY: stall=1, mem_req held at 1 and all mem_* outputs held stable.
  - Timeout counter increments each BUSY cycle.
  - If mem_ack=1: capture the formatted load into the rData register, drop mem_req, and go to DONE. For a store, rData is captured as 0.
  - If the counter reaches TIMEOUT with no ack: drop mem_req, set rData=0, pulse bus_err for one cycle, and go to DONE.
- Load formatting, using the latched lane L=Addr[1:0]:
  - byte: mem_rdata[8L+7:8L], extended to 32 bits.
  - halfword: mem_rdata[8L+15:8L], extended to 32 bits.
  - word: unmodified.
- DONE: stall=0 and rData holds its value. The MEM/WB register captures on this edge. Next state is IDLE unconditionally, and the counter clears.
- mem_ack arriving in IDLE or DONE is ignored.
- Reset asserted mid-access: all state and outputs clear immediately and mem_req drops. The external memory must tolerate an abandoned request.

## Timing
- Reset values: rData=0, stall=0 (follows IDLE decode), misalign=0, bus_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, state IDLE, counter 0.
- Zero-wait memory (ack in the first BUSY cycle):
  - cycle 0: IDLE, stall=1.
  - cycle 1: BUSY, mem_req=1, ack.
  - cycle 2: DONE, stall=0, rData valid.
  - Memory instruction occupancy is 3 cycles.
- Each wait cycle of memory adds one cycle.
- Timeout: bus_err is asserted in the DONE cycle that follows TIMEOUT BUSY cycles.
- Non-memory instructions and misaligned accesses complete in 1 cycle with no stall.
- Result and wAddr are purely combinational. Upstream holds Addr and wAddr_i stable while stall=1.

## Test plan
- Reset mid-BUSY (mem_req=1), then release: all outputs 0, state IDLE; the next instruction is accepted normally.
- Store word, Addr=0x100, wData_i=0xDEADBEEF, ack after 2 wait cycles:
  - Bus: mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1.
  - stall high for 4 cycles.
- Load byte signed, Addr=0x203, mem_rdata=0x80112233, zero-wait: mem_be=1000, rData=0xFFFFFF80 in DONE, stall=0 for exactly that cycle.
- Load halfword unsigned, Addr=0x202, mem_rdata=0x80FF0000: rData=0x000080FF. The signed variant gives rData=0xFFFF80FF.
- Load word, Addr=0x105: misalign=1, stall=0, mem_req stays 0, rData=0.
- Store byte, Addr=0x001, wData_i=0x000000AB: mem_be=0010, mem_wdata=0xABABABAB.
- Never ack, TIMEOUT=4: mem_req high for 4 cycles, then bus_err pulses one cycle with rData=0, and the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access stage: drives a word-wide ready/ack bus for loads and
// stores, steers byte lanes, formats load data and stalls until completion.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] wData_i,
  input  logic [4:0]  wAddr_i,
  output logic [31:0] rData,
  output logic [31:0] Result,
  output logic [4:0]  wAddr,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Counter value seen in the last BUSY cycle before giving up.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;

  logic        mem_op;
  logic        is_half;
  logic        is_word;
  logic        mis;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] rshift;
  logic [31:0] load_fmt;

  // Decode the incoming instruction: alignment, byte enables, store data.
  always_comb begin
    mem_op  = MemRead | MemWrite;
    is_half = (Size == 2'b01);
    is_word = Size[1];
    mis     = mem_op & ((is_half & Addr[0]) | (is_word & (Addr[1:0] != 2'b00)));
    be_new    = 4'b1111;
    wdata_new = wData_i;
    unique case (Size)
      2'b00: begin
        be_new    = 4'b0001 << Addr[1:0];
        wdata_new = {4{wData_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << Addr[1:0];
        wdata_new = {2{wData_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wData_i;
      end
    endcase
  end

  // Format read data from the latched lane, size and signedness.
  always_comb begin
    rshift   = mem_rdata >> {lane_q, 3'b000};
    load_fmt = mem_rdata;
    unique case (size_q)
      2'b00:   load_fmt = {{24{~uns_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_fmt = {{16{~uns_q & rshift[15]}}, rshift[15:0]};
      default: load_fmt = mem_rdata;
    endcase
  end

  // Next-state logic for the access FSM and all registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    lane_d    = lane_q;
    unique case (state_q)
      StIdle: begin
        rdata_d = '0;
        cnt_d   = '0;
        if (mem_op && !mis) begin
          req_d   = 1'b1;
          we_d    = MemWrite & ~MemRead;
          addr_d  = {Addr[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          size_d  = Size;
          uns_d   = Unsigned;
          lane_d  = Addr[1:0];
          state_d = StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ack) begin
          rdata_d = we_q ? 32'h0 : load_fmt;
          req_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          rdata_d   = '0;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        // rData stays visible for this cycle only; cleared on return to IDLE.
        rdata_d = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      lane_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      lane_q    <= lane_d;
    end
  end

  // Output decode: stall covers accept cycle and BUSY, not DONE.
  always_comb begin
    stall     = ((state_q == StIdle) & mem_op & ~mis) | (state_q == StBusy);
    misalign  = (state_q == StIdle) & mis;
    rData     = rdata_q;
    bus_err   = bus_err_q;
    mem_req   = req_q;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_be    = be_q;
    mem_wdata = wdata_q;
    Result    = Addr;
    wAddr     = wAddr_i;
  end

endmodule
